// File: rtl/sfp_pkg.sv
// Shared types and width helpers for the row-normalisation block.
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  function automatic int sum_w(input int bw, input int col);
    return bw + $clog2(col);
  endfunction

  function automatic int div_n(input int bw, input int frac);
    return bw + frac;
  endfunction

endpackage

// File: rtl/sfp_fifo.sv
// Show-ahead FIFO with wrap-bit pointers, full/empty flags and occupancy.
module sfp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == {1'b1, {AW{1'b0}}});
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sfp_row_norm.sv
// Row normaliser: accumulates |lane| sums, then divides each lane by the
// (optionally two-core) row sum with a shared-divisor restoring divider.
module sfp_row_norm
  import sfp_pkg::*;
#(
  parameter int COL     = 8,
  parameter int BW_PSUM = 20,
  parameter int DEPTH   = 16,
  parameter int FRAC    = 8,
  localparam int SUM_W  = sum_w(BW_PSUM, COL),
  localparam int DIV_N  = div_n(BW_PSUM, FRAC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     two_core,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic                     div_valid,
  output logic                     div_ready,
  input  logic [COL*BW_PSUM-1:0]   sfp_in,
  input  logic [SUM_W-1:0]         ext_sum_in,
  input  logic                     ext_rd,
  output logic [SUM_W-1:0]         sum_out,
  output logic [COL*BW_PSUM-1:0]   sfp_out,
  output logic                     out_valid,
  output logic                     div_zero,
  output logic                     int_empty,
  output logic                     ext_full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(DIV_N);
  localparam logic [NW-1:0] LAST = NW'(DIV_N - 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [DIV_N-1:0] QMAXP =
    {{(DIV_N-BW_PSUM+1){1'b0}}, {(BW_PSUM-1){1'b1}}};
  localparam logic [DIV_N-1:0] QMAXN =
    {{(DIV_N-BW_PSUM){1'b0}}, 1'b1, {(BW_PSUM-1){1'b0}}};

  state_e state_q, state_d;

  logic [BW_PSUM-1:0] mag_c [COL];
  logic [COL-1:0]     neg_c;
  logic [SUM_W-1:0]   sum_c;

  logic               push_q;
  logic [SUM_W-1:0]   s_q;
  logic [SUM_W-1:0]   sum_q;

  logic [SUM_W-1:0]   int_dout, ext_dout;
  logic               int_full, ext_full_raw, ext_empty;
  logic [CW-1:0]      int_cnt, ext_cnt;
  logic [CW:0]        int_lvl, ext_lvl;

  logic               acc_fire, div_fire, ext_pop;

  logic [SUM_W:0]     d_q;
  logic               d_zero;
  logic [COL-1:0]     neg_q;
  logic [DIV_N-1:0]   q_q  [COL];
  logic [SUM_W:0]     r_q  [COL];
  logic [DIV_N-1:0]   q_nx [COL];
  logic [SUM_W:0]     r_nx [COL];
  logic [SUM_W+1:0]   sh   [COL];
  logic [NW-1:0]      cnt_q;

  logic [COL*BW_PSUM-1:0] sat_c;
  logic [COL*BW_PSUM-1:0] sfp_q;
  logic               ov_q, dz_q;

  always_comb begin
    sum_c = '0;
    neg_c = '0;
    for (int i = 0; i < COL; i++) begin
      neg_c[i] = sfp_in[i*BW_PSUM + BW_PSUM-1];
      mag_c[i] = neg_c[i] ? (~sfp_in[i*BW_PSUM +: BW_PSUM] + 1'b1)
                          : sfp_in[i*BW_PSUM +: BW_PSUM];
      sum_c    = sum_c + SUM_W'(mag_c[i]);
    end
  end

  // Occupancy includes the registered push that has not landed yet.
  assign int_lvl   = {1'b0, int_cnt} + (CW+1)'(push_q);
  assign ext_lvl   = {1'b0, ext_cnt} + (CW+1)'(push_q);
  assign ext_full  = ext_full_raw || (ext_lvl >= DEPTH_L);
  assign acc_ready = !(int_full || (int_lvl >= DEPTH_L)) && !ext_full;
  assign div_ready = (state_q == IDLE) && !int_empty;
  assign acc_fire  = acc_valid && acc_ready;
  assign div_fire  = div_valid && div_ready;
  assign ext_pop   = ext_rd && !ext_empty;

  sfp_fifo #(.W(SUM_W), .DEPTH(DEPTH)) u_int_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .din_i   (s_q),
    .pop_i   (div_fire),
    .dout_o  (int_dout),
    .full_o  (int_full),
    .empty_o (int_empty),
    .count_o (int_cnt)
  );

  sfp_fifo #(.W(SUM_W), .DEPTH(DEPTH)) u_ext_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .din_i   (s_q),
    .pop_i   (ext_pop),
    .dout_o  (ext_dout),
    .full_o  (ext_full_raw),
    .empty_o (ext_empty),
    .count_o (ext_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (div_fire) state_d = DIV;
      DIV:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      sh[i]   = {r_q[i], q_q[i][DIV_N-1]};
      r_nx[i] = sh[i][SUM_W:0];
      q_nx[i] = {q_q[i][DIV_N-2:0], 1'b0};
      if (sh[i] >= {1'b0, d_q}) begin
        r_nx[i] = (SUM_W+1)'(sh[i] - {1'b0, d_q});
        q_nx[i] = {q_q[i][DIV_N-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    sat_c = '0;
    for (int i = 0; i < COL; i++) begin
      if (!neg_q[i])
        sat_c[i*BW_PSUM +: BW_PSUM] = (q_q[i] > QMAXP) ?
          QMAXP[BW_PSUM-1:0] : q_q[i][BW_PSUM-1:0];
      else
        sat_c[i*BW_PSUM +: BW_PSUM] = (q_q[i] > QMAXN) ?
          QMAXN[BW_PSUM-1:0] : (~q_q[i][BW_PSUM-1:0] + 1'b1);
    end
  end

  assign d_zero = (d_q == '0);

  always_ff @(posedge clk) begin
    if (div_fire) begin
      d_q   <= {1'b0, int_dout} + (two_core ? {1'b0, ext_sum_in} : '0);
      neg_q <= neg_c;
      for (int i = 0; i < COL; i++) begin
        q_q[i] <= {mag_c[i], {FRAC{1'b0}}};
        r_q[i] <= '0;
      end
    end else if (state_q == DIV) begin
      for (int i = 0; i < COL; i++) begin
        q_q[i] <= q_nx[i];
        r_q[i] <= r_nx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      s_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sfp_q   <= '0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= acc_fire;
      if (acc_fire) s_q <= sum_c;
      if (ext_pop) sum_q <= ext_dout;
      cnt_q   <= (state_q == DIV) ? cnt_q + 1'b1 : '0;
      ov_q    <= (state_q == DONE);
      if (state_q == DONE) begin
        sfp_q <= d_zero ? '0 : sat_c;
        dz_q  <= d_zero;
      end
    end
  end

  assign sum_out   = sum_q;
  assign sfp_out   = sfp_q;
  assign out_valid = ov_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_sfp_row_norm.sv
// Scoreboard bench for sfp_row_norm with directed vectors.
module tb_sfp_row_norm;

  localparam int BW = 20;
  localparam int SW = 23;
  localparam int DN = 28;
  localparam int VW = 160;

  logic          clk = 1'b0;
  logic          reset;
  logic          two_core;
  logic          acc_valid;
  logic          acc_ready;
  logic          div_valid;
  logic          div_ready;
  logic [VW-1:0] sfp_in;
  logic [SW-1:0] ext_sum_in;
  logic          ext_rd;
  logic [SW-1:0] sum_out;
  logic [VW-1:0] sfp_out;
  logic          out_valid;
  logic          div_zero;
  logic          int_empty;
  logic          ext_full;

  always #5 clk = ~clk;

  sfp_row_norm dut (
    .clk        (clk),
    .reset      (reset),
    .two_core   (two_core),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .sfp_in     (sfp_in),
    .ext_sum_in (ext_sum_in),
    .ext_rd     (ext_rd),
    .sum_out    (sum_out),
    .sfp_out    (sfp_out),
    .out_valid  (out_valid),
    .div_zero   (div_zero),
    .int_empty  (int_empty),
    .ext_full   (ext_full)
  );

  typedef struct {
    logic [VW-1:0] v;
    logic          z;
    int            c;
  } exp_t;

  exp_t          eq[$];
  logic [SW-1:0] sq[$];
  logic [SW-1:0] last_sum = '0;
  exp_t          mon_e;
  logic          rd_fire = 1'b0;
  int            ntests = 0;
  int            nfail = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_fire <= ext_rd && !reset;

  task automatic chk(input string name, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input int a0, input int a1,
                                         input int a2, input int a3);
    return {80'd0, BW'(a3), BW'(a2), BW'(a1), BW'(a0)};
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (eq.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_out_valid: sfp_out %h, none pending", sfp_out);
      end else begin
        mon_e = eq.pop_front();
        chk("sfp_out", sfp_out, mon_e.v);
        chk("div_zero", VW'(div_zero), VW'(mon_e.z));
        chk("latency", VW'(cyc - mon_e.c), VW'(DN + 1));
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last_sum = '0;
    end else if (rd_fire) begin
      if (sq.size() > 0) last_sum = sq.pop_front();
      chk("sum_out", VW'(sum_out), VW'(last_sum));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sq.delete();
    eq.delete();
  endtask

  task automatic do_acc(input logic [VW-1:0] v, input logic [SW-1:0] s);
    @(negedge clk);
    chk("acc_ready", VW'(acc_ready), VW'(1));
    sfp_in = v;
    acc_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    sq.push_back(s);
  endtask

  task automatic do_div(input logic [VW-1:0] v, input logic tc,
                        input logic [SW-1:0] ext, input logic [VW-1:0] ev,
                        input logic ez, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!div_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("div_ready", VW'(div_ready), VW'(1));
    sfp_in = v;
    two_core = tc;
    ext_sum_in = ext;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    two_core = 1'b0;
    if (track) begin
      e.v = ev;
      e.z = ez;
      e.c = cyc;
      eq.push_back(e);
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (eq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (eq.size() > 0) begin
      nfail++;
      $display("FAIL out_timeout: %0d results pending, expected 0", eq.size());
      eq.delete();
    end
  endtask

  logic [VW-1:0] v1;

  initial begin
    reset = 1'b1;
    two_core = 1'b0;
    acc_valid = 1'b0;
    div_valid = 1'b0;
    sfp_in = '0;
    ext_sum_in = '0;
    ext_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_acc_ready", VW'(acc_ready), VW'(1));
    chk("rst_div_ready", VW'(div_ready), VW'(0));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_sfp_out", sfp_out, '0);
    chk("rst_sum_out", VW'(sum_out), '0);
    chk("rst_int_empty", VW'(int_empty), VW'(1));
    chk("rst_ext_full", VW'(ext_full), VW'(0));
    chk("rst_div_zero", VW'(div_zero), VW'(0));

    // fill both FIFOs, then drain the external one
    for (int k = 0; k < 16; k++)
      do_acc(vec(k + 1, -(2 * k), 0, 0), SW'(3 * k + 1));
    @(negedge clk);
    chk("full_acc_ready", VW'(acc_ready), VW'(0));
    chk("full_ext_full", VW'(ext_full), VW'(1));
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      ext_rd = 1'b1;
      @(negedge clk);
      ext_rd = 1'b0;
    end
    chk("empty_rd_hold", VW'(sum_out), VW'(46));
    chk("intfull_acc_ready", VW'(acc_ready), VW'(0));
    chk("intfull_not_empty", VW'(int_empty), VW'(0));
    do_reset();

    v1 = vec(100, -100, 50, -50);
    do_acc(v1, 23'd300);
    do_div(v1, 1'b0, '0, vec(85, -85, 42, -42), 1'b0, 1'b1);
    wait_out();
    repeat (10) @(negedge clk);
    chk("hold_sfp_out", sfp_out, vec(85, -85, 42, -42));

    do_acc(v1, 23'd300);
    do_div(v1, 1'b1, 23'd300, vec(42, -42, 21, -21), 1'b0, 1'b1);
    wait_out();

    do_acc('0, '0);
    do_div('0, 1'b0, '0, '0, 1'b1, 1'b1);
    wait_out();
    repeat (5) @(negedge clk);
    chk("hold_div_zero", VW'(div_zero), VW'(1));

    do_acc(vec(-524288, 0, 0, 0), 23'd524288);
    do_div(vec(-524288, 0, 0, 0), 1'b0, '0, vec(-256, 0, 0, 0), 1'b0, 1'b1);
    wait_out();

    do_acc(vec(1, 0, 0, 0), 23'd1);
    do_div(vec(524287, -524288, 0, 0), 1'b0, '0,
           vec(524287, -524288, 0, 0), 1'b0, 1'b1);
    wait_out();

    // reset in the middle of a divide
    do_acc(v1, 23'd300);
    do_div(v1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sq.delete();
    @(negedge clk);
    chk("midrst_out_valid", VW'(out_valid), VW'(0));
    chk("midrst_int_empty", VW'(int_empty), VW'(1));
    chk("midrst_sfp_out", sfp_out, '0);
    chk("midrst_div_ready", VW'(div_ready), VW'(0));
    chk("midrst_acc_ready", VW'(acc_ready), VW'(1));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("postrst_sfp_out", sfp_out, '0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sfp_row_norm.md
SFP_ROW_NORM -- requirements
Module: sfp_row_norm

Interface
REQ-001 SHALL have parameter COL, default 8, meaning psum lanes per row.
REQ-002 SHALL have parameter BW_PSUM, default 20, meaning signed psum width per lane.
REQ-003 SHALL have parameter DEPTH, default 16, meaning entries per sum FIFO; it must be a power of 2 and at least 2.
REQ-004 SHALL have parameter FRAC, default 8, meaning fractional bits of the normalised output.
REQ-005 SHALL use the derived widths SUM_W = BW_PSUM + clog2(COL) and DIV_N = BW_PSUM + FRAC.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- two_core, input, 1, mode: 1 adds ext_sum_in to the divisor.
- acc_valid, input, 1, sfp_in carries a vector to accumulate.
- acc_ready, output, 1, an accumulate can be accepted.
- div_valid, input, 1, sfp_in carries a vector to normalise.
- div_ready, output, 1, a divide can be accepted.
- sfp_in, input, COL*BW_PSUM, packed signed lanes, lane 0 in the LSBs.
- ext_sum_in, input, SUM_W, sum from the partner core.
- ext_rd, input, 1, pop the external-sum FIFO.
- sum_out, output, SUM_W, head of the external-sum FIFO, registered.
- sfp_out, output, COL*BW_PSUM, normalised signed lanes.
- out_valid, output, 1, one-cycle strobe: sfp_out is new.
- div_zero, output, 1, the divisor of the current sfp_out was 0.
- int_empty, output, 1, internal sum FIFO empty.
- ext_full, output, 1, external sum FIFO full.

Function
REQ-007 SHALL accept an accumulate on any cycle where acc_valid and acc_ready are both high.
REQ-008 SHALL compute, on accept, S = the unsigned sum of |lane| over all COL lanes in SUM_W bits; |most-negative value| = 2^(BW_PSUM-1) exactly.
REQ-009 SHALL push S into both the internal and external FIFOs on the edge after accept (1-cycle latency).
REQ-010 SHALL drive acc_ready = !int_full && !ext_full, where fullness counts the pending push.
REQ-011 SHALL pop the external FIFO on ext_rd and load its head into sum_out on the same edge; ext_rd when empty is ignored and sum_out holds its value.
REQ-012 SHALL implement a state machine with states IDLE, DIV and DONE.
REQ-013 SHALL drive div_ready = (state == IDLE) && !int_empty.
REQ-014 SHALL, on div accept in IDLE:
- pop the internal FIFO;
- latch D = head + (two_core ? ext_sum_in : 0), width SUM_W+1;
- latch the signs and magnitudes of all lanes;
- go to DIV.
REQ-015 SHALL, in DIV, run a shared-divisor restoring divider on all lanes in parallel, one quotient bit per cycle, for exactly DIV_N cycles, computing (|x| << FRAC) / D, then go to DONE.
REQ-016 SHALL, in DONE, negate each quotient whose lane sign was negative, saturate it to the signed BW_PSUM range, register it on sfp_out, pulse out_valid for one cycle, and return to IDLE.
REQ-017 SHALL assert out_valid exactly DIV_N+1 cycles after the div-accept edge.
REQ-018 SHALL, when D == 0, output all-zero lanes, set div_zero, and keep the same latency; div_zero is otherwise 0 and is updated together with sfp_out.
REQ-019 SHALL hold sfp_out and div_zero between results.
REQ-020 SHALL allow an accumulate and a divide to be accepted in the same cycle; the pop uses the pre-push head, and an empty FIFO never satisfies div_ready in that cycle.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH; a simultaneous push and pop on a full FIFO is disallowed because acc_ready is low.

Reset
REQ-022 SHALL, on reset, set the following, overriding any in-flight divide:
- state = IDLE;
- FIFOs empty;
- sfp_out = 0, sum_out = 0;
- out_valid = 0, div_zero = 0;
- acc_ready = 1, div_ready = 0.

Structure
REQ-023 SHALL place the state encoding and the SUM_W/DIV_N width functions in the shared package sfp_pkg.
REQ-024 SHALL instantiate one sub-module sfp_fifo (parametrised width and depth, show-ahead read, full/empty flags), twice.

Verification
REQ-025 SHALL pass directed scenario 1: lanes {100,-100,50,-50,0,0,0,0}, two_core=0, accumulate then divide -> D=300; lane0 = 100*256/300 = 85, lane1 = -85, lane2 = 42, lane3 = -42, at cycle DIV_N+1.
REQ-026 SHALL pass directed scenario 2: two_core=1, ext_sum_in=300, same vector -> D=600; lane0 = 42, lane1 = -42.
REQ-027 SHALL pass directed scenario 3: all lanes 0, accumulate then divide -> div_zero=1 and sfp_out=0.
REQ-028 SHALL pass directed scenario 4: lane0 = -2^19, other lanes 0, FRAC=8 -> D = 2^19; quotient 256 is negated to -256 with no saturation; with lane0 = 2^19-1 and D=1, the output saturates to 2^19-1.
REQ-029 SHALL pass directed scenario 5: 16 accumulates with no divides -> acc_ready low after the 16th; ext_rd while empty leaves sum_out unchanged; 16 ext_rd calls return the sums in order.
REQ-030 SHALL pass directed scenario 6: reset asserted at DIV cycle 5 -> no out_valid, FIFOs empty, sfp_out = 0 on the next cycle.
